div_seq_unit: RTL and testbench

//  Iterative RV32M divider (DIV/DIVU/REM/REMU) in the EX stage, one quotient bit per clock.

---
 rtl/div_seq_unit.sv | 138 +++++++++++++
 tb/tb_div_seq_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/div_seq_unit.sv
// div_seq_unit: iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per clock.
// Divide-by-zero and signed-overflow resolve in IDLE and skip the CALC loop.
module div_seq_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            flush,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            hold,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            qneg_q, qneg_d;     // quotient must be negated
  logic            rneg_q, rneg_d;     // remainder must be negated
  logic [XLEN-1:0] quo_q, quo_d;       // dividend magnitude shifting out, quotient shifting in
  logic [XLEN-1:0] rem_q, rem_d;       // partial remainder
  logic [XLEN-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic [XLEN-1:0] result_q, result_d;

  // Restoring step datapath, evaluated every cycle and used only in CALC
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx, quo_nx;
  logic            sgn_op, a_neg, b_neg;

  // One shift-subtract iteration from the current partial remainder/quotient
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    ge     = ~diff[XLEN];
    rem_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], ge};
  end

  // Next-state and datapath update for the IDLE/CALC/DONE sequence
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    sgn_op   = ~op[0];
    a_neg    = sgn_op & dividend[XLEN-1];
    b_neg    = sgn_op & divisor[XLEN-1];
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d   = op;
          quo_d  = a_neg ? -dividend : dividend;
          dvs_d  = b_neg ? -divisor : divisor;
          rem_d  = '0;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          if (divisor == '0) begin
            // REM returns the untouched dividend, DIV returns all-ones
            result_d = op[1] ? dividend : '1;
            state_d  = DONE;
          end else if (sgn_op && dividend == INT_MIN && divisor == '1) begin
            result_d = op[1] ? '0 : dividend;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            state_d  = DONE;
            result_d = op_q[1] ? (rneg_q ? -rem_nx : rem_nx)
                               : (qneg_q ? -quo_nx : quo_nx);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
    end
  end

  // hold drops in DONE so EX/MEM captures result on the edge leaving DONE
  assign hold   = ((state_q == IDLE) & start & ~flush) | (state_q == CALC);
  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// tb_div_seq_unit: table-driven directed vectors plus flush/clr/start-while-busy sequences.
module tb_div_seq_unit;

  logic        clk = 1'b0;
  logic        clr, flush, start;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        hold, busy, done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
  localparam int INJ_NONE = 0, INJ_FLUSH = 1, INJ_START = 2, INJ_CLR = 3;

  div_seq_unit #(.XLEN(32)) dut (
    .clk(clk), .clr(clr), .flush(flush), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .hold(hold), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE; start is cycle 0. exp_lat=0 means the op is aborted
  // by the injected flush/clr at cycle inj_c and IDLE is checked in cycle inj_c+1.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input int inj_c, input int inj_k);
    int lat = 0;
    bit hold_ok = 1'b1;
    op = o; dividend = a; divisor = b; start = 1'b1;
    #1;
    chk({nm, " hold_c0"}, 32'(hold), 32'd1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0; clr = 1'b0;
      dividend = $urandom; divisor = $urandom;
      #1;
      if ((inj_k == INJ_FLUSH || inj_k == INJ_CLR) && c == inj_c + 1) break;
      if (done) begin lat = c; break; end
      if (hold !== 1'b1 || busy !== 1'b1) hold_ok = 1'b0;
      if (c == inj_c) begin
        case (inj_k)
          INJ_FLUSH: flush = 1'b1;
          INJ_START: begin start = 1'b1; op = OP_DIVU; dividend = 32'd9; divisor = 32'd3; end
          INJ_CLR:   clr = 1'b1;
          default: ;
        endcase
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " hold_busy_in_flight"}, 32'(hold_ok), 32'd1);
    chk({nm, " result"}, result, exp_res);
    if (exp_lat > 0) begin
      chk({nm, " hold_in_done"}, 32'(hold), 32'd0);
      @(negedge clk); #1;
      chk({nm, " done_one_cycle"}, 32'(done), 32'd0);
    end else begin
      chk({nm, " aborted_busy"}, 32'(busy), 32'd0);
      chk({nm, " aborted_done"}, 32'(done), 32'd0);
    end
    chk({nm, " idle_hold"}, 32'(hold), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{OP_DIV,  32'd100,        32'd7,          32'd14,         33},
      '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33},
      '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33},
      '{OP_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33},
      '{OP_REM,  32'd100,        32'd7,          32'd2,          33},
      '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33},
      '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33},
      '{OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          33},
      '{OP_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  33},
      '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33},
      '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1},
      '{OP_REMU, 32'd5,          32'd0,          32'd5,          1},
      '{OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1},
      '{OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1},
      '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1},
      '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1}
    };

    clr = 1'b1; flush = 1'b0; start = 1'b0; op = '0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); clr = 1'b0; #1;
    chk("reset busy",   32'(busy), 32'd0);
    chk("reset done",   32'(done), 32'd0);
    chk("reset result", result,    32'd0);
    chk("reset hold",   32'(hold), 32'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat, 0, INJ_NONE);

    // flush in IDLE blocks start
    op = OP_DIV; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1; #1;
    chk("flush_idle hold", 32'(hold), 32'd0);
    @(negedge clk); start = 1'b0; flush = 1'b0; #1;
    chk("flush_idle busy", 32'(busy), 32'd0);
    chk("flush_idle done", 32'(done), 32'd0);

    // flush mid-CALC: previous result (0 from REM overflow) must survive; restart at cycle 12
    run_op("flush_calc", OP_DIV, 32'd1000, 32'd3, 32'd0, 0, 10, INJ_FLUSH);
    @(negedge clk);
    run_op("after_flush", OP_DIV, 32'd1000, 32'd3, 32'd333, 33, 0, INJ_NONE);

    // start while busy is ignored and not queued
    run_op("start_busy", OP_DIVU, 32'd77, 32'd5, 32'd15, 33, 5, INJ_START);
    repeat (3) @(negedge clk);
    #1;
    chk("no_queue busy", 32'(busy), 32'd0);
    chk("no_queue done", 32'(done), 32'd0);

    // clr during CALC clears everything and no done appears later
    run_op("clr_calc", OP_DIV, 32'd100, 32'd7, 32'd0, 0, 5, INJ_CLR);
    begin
      bit saw_done = 1'b0;
      repeat (40) begin
        @(negedge clk); #1;
        if (done || busy) saw_done = 1'b1;
      end
      chk("clr no_late_done", 32'(saw_done), 32'd0);
    end

    run_op("after_clr", OP_REMU, 32'd1000, 32'd7, 32'd6, 33, 0, INJ_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
